// File: rtl/alu_pkg.sv
// Shared types and op-classification helpers for the alu_md_unit execute block.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd1,  OP_SUB    = 5'd2,  OP_AND   = 5'd3,  OP_OR    = 5'd4,
    OP_XOR    = 5'd5,  OP_SLT    = 5'd6,  OP_SLTU  = 5'd7,  OP_SRA   = 5'd8,
    OP_SRL    = 5'd9,  OP_SLL    = 5'd10, OP_ADDI  = 5'd11, OP_ANDI  = 5'd12,
    OP_ORI    = 5'd13, OP_XORI   = 5'd14, OP_SLTI  = 5'd15, OP_SLTIU = 5'd16,
    OP_SRAI   = 5'd17, OP_SRLI   = 5'd18, OP_SLLI  = 5'd19,
    OP_MUL    = 5'd20, OP_MULH   = 5'd21, OP_MULHSU = 5'd22, OP_MULHU = 5'd23,
    OP_DIV    = 5'd24, OP_DIVU   = 5'd25, OP_REM   = 5'd26, OP_REMU  = 5'd27
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_legal(alu_op_e op);
    return (op >= OP_ADD) && (op <= OP_REMU);
  endfunction

  function automatic logic is_muldiv(alu_op_e op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div(alu_op_e op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

  function automatic logic is_signed_a(alu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(alu_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide engine, one step per clock.
// acc holds {hi, lo}: product for multiply, {remainder, quotient} for divide.
module alu_md_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic              done_o,
  output logic [2*XLEN-1:0] result_o
);
  localparam int SHW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc_q, acc_d, acc_nxt;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              div_q, div_d;

  logic [XLEN:0]     msum;
  logic [XLEN:0]     dshift;
  logic [XLEN-1:0]   ddiff;
  logic              dge;

  always_comb begin
    msum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    dshift = acc_q[2*XLEN-1:XLEN-1];
    dge    = dshift >= {1'b0, opnd_q};
    // remainder after a successful subtract is below the divisor, so XLEN bits suffice
    ddiff  = dshift[XLEN-1:0] - opnd_q;
    if (div_q)
      acc_nxt = dge ? {ddiff, acc_q[XLEN-2:0], 1'b1} : {acc_q[2*XLEN-2:0], 1'b0};
    else
      acc_nxt = {msum, acc_q[XLEN-1:1]};
  end

  assign done_o   = busy_q && (cnt_q == SHW'(XLEN-1));
  assign result_o = acc_nxt;

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    div_d  = div_q;
    if (clear_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      div_d  = is_div_i;
      opnd_d = is_div_i ? b_i : a_i;
      acc_d  = {{XLEN{1'b0}}, is_div_i ? a_i : b_i};
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = acc_nxt;
      cnt_d = cnt_q + 1'b1;
      if (done_o) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      div_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      div_q  <= div_d;
    end
  end

endmodule

// File: rtl/alu_md_unit.sv
// Handshaked RV32I/RV32M execute unit: registered base ops, iterative mul/div.
// IDLE: waiting for a bundle | CALC: mul/div iterating | DONE: result held until consumed
module alu_md_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] in1_i,
  input  logic [XLEN-1:0] in2_i,
  input  logic [4:0]      op_i,
  input  logic            kill_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_o,
  output logic            zero_o,
  output logic            illegal_o
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  alu_state_e        state_q, state_d;
  alu_op_e           op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]   out_q, out_d;
  logic              zero_q, zero_d, ill_q, ill_d;

  alu_op_e           op_e;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   base_res, fast_res, md_res, mag_a, mag_b;
  logic              legal, div0, ovf, fast, sa, sb, accept, start;
  logic              iter_done;
  logic [2*XLEN-1:0] iter_res, prod;

  assign op_e  = alu_op_e'(op_i);
  assign shamt = in2_i[SHW-1:0];
  assign legal = is_legal(op_e);

  always_comb begin
    base_res = '0;
    case (op_e)
      OP_ADD,  OP_ADDI:  base_res = in1_i + in2_i;
      OP_SUB:            base_res = in1_i - in2_i;
      OP_AND,  OP_ANDI:  base_res = in1_i & in2_i;
      OP_OR,   OP_ORI:   base_res = in1_i | in2_i;
      OP_XOR,  OP_XORI:  base_res = in1_i ^ in2_i;
      OP_SLT,  OP_SLTI:  base_res = {{(XLEN-1){1'b0}}, $signed(in1_i) < $signed(in2_i)};
      OP_SLTU, OP_SLTIU: base_res = {{(XLEN-1){1'b0}}, in1_i < in2_i};
      OP_SRA,  OP_SRAI:  base_res = $unsigned($signed(in1_i) >>> shamt);
      OP_SRL,  OP_SRLI:  base_res = in1_i >> shamt;
      OP_SLL,  OP_SLLI:  base_res = in1_i << shamt;
      default:           base_res = '0;
    endcase
  end

  // Divide corner cases resolve in one cycle and never enter the iterator
  always_comb begin
    div0     = (in2_i == '0);
    ovf      = ((op_e == OP_DIV) || (op_e == OP_REM)) && (in1_i == MOST_NEG) && (in2_i == '1);
    fast     = is_div(op_e) && (div0 || ovf);
    fast_res = '0;
    if (div0)
      fast_res = ((op_e == OP_DIV) || (op_e == OP_DIVU)) ? '1 : in1_i;
    else if (op_e == OP_DIV)
      fast_res = in1_i;
    sa    = is_signed_a(op_e) & in1_i[XLEN-1];
    sb    = is_signed_b(op_e) & in2_i[XLEN-1];
    mag_a = sa ? -in1_i : in1_i;
    mag_b = sb ? -in2_i : in2_i;
  end

  always_comb begin
    prod   = (sa_q ^ sb_q) ? -iter_res : iter_res;
    md_res = '0;
    case (op_q)
      OP_MUL:                        md_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  md_res = prod[2*XLEN-1:XLEN];
      OP_DIV:  md_res = (sa_q ^ sb_q) ? -iter_res[XLEN-1:0] : iter_res[XLEN-1:0];
      OP_DIVU: md_res = iter_res[XLEN-1:0];
      OP_REM:  md_res = sa_q ? -iter_res[2*XLEN-1:XLEN] : iter_res[2*XLEN-1:XLEN];
      OP_REMU: md_res = iter_res[2*XLEN-1:XLEN];
      default: md_res = '0;
    endcase
  end

  assign in_ready_o  = ~rst_i & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready_i));
  assign out_valid_o = (state_q == S_DONE);
  assign out_o       = out_q;
  assign zero_o      = zero_q;
  assign illegal_o   = ill_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    out_d   = out_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    accept  = 1'b0;
    start   = 1'b0;
    if (kill_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: accept = in_valid_i;
        S_CALC: begin
          if (iter_done) begin
            state_d = S_DONE;
            out_d   = md_res;
            zero_d  = (md_res == '0);
            ill_d   = 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            state_d = S_IDLE;
            accept  = in_valid_i;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (accept) begin
        op_d = op_e;
        sa_d = sa;
        sb_d = sb;
        if (is_muldiv(op_e) && !fast) begin
          state_d = S_CALC;
          start   = 1'b1;
        end else begin
          state_d = S_DONE;
          out_d   = fast ? fast_res : base_res;
          zero_d  = fast ? (fast_res == '0) : (base_res == '0);
          ill_d   = ~legal;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end

  alu_md_iter #(.XLEN(XLEN)) u_iter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (kill_i),
    .start_i  (start),
    .is_div_i (is_div(op_e)),
    .a_i      (mag_a),
    .b_i      (mag_b),
    .done_o   (iter_done),
    .result_o (iter_res)
  );

endmodule

// File: doc/alu_md_unit.md
# alu_md_unit

Handshaked, parametrised execute unit that supersedes the single-cycle combinational ALU. It supports the full RV32I integer op set plus the RV32M multiply/divide ops, at width `XLEN`. Base ops complete in one registered cycle. Multiply/divide run on an iterative shift-add / restoring-divide datapath. The unit sits in the EX stage; the pipeline stalls on `in_ready`/`out_valid`.

## Interface
- `XLEN`, 32, datapath width; power of two, ≥8.
- `SHW`, $clog2(XLEN), shift-amount width (derived, not overridden).
- `clk  in  1`  clock, single domain.
- `rst  in  1`  reset, synchronous, active-high.
- `in_valid  in  1`  operand/op bundle valid.
- `in_ready  out  1`  unit can accept a bundle this cycle.
- `in1  in  XLEN`  operand A (rs1).
- `in2  in  XLEN`  operand B (rs2 or immediate).
- `op  in  5`  operation code.
- `kill  in  1`  synchronous abort of any in-flight op (pipeline flush).
- `out_valid  out  1`  result valid.
- `out_ready  in  1`  consumer takes result.
- `out  out  XLEN`  registered result.
- `zero  out  1`  registered, 1 when `out == 0`.
- `illegal  out  1`  registered, 1 when op was unrecognised; qualified by `out_valid`.

## Operation
- Op codes 1–19 are unchanged: ADD, SUB, AND, OR, XOR, SLT, SLTU, SRA, SRL, SLL, ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SRAI, SRLI, SLLI.
- New op codes: 20 MUL, 21 MULH, 22 MULHSU, 23 MULHU, 24 DIV, 25 DIVU, 26 REM, 27 REMU.
- Any other code gives `out=0`, `zero=1`, `illegal=1`, with 1-cycle latency.
- Shifts use `in2[SHW-1:0]`. SRA/SRAI are arithmetic on signed `in1`.
- FSM states are IDLE, CALC, DONE.
  - IDLE: accept when `in_valid` is high. Base, illegal and fast-path div ops go to DONE; mul/div ops go to CALC with `cnt=0`.
  - CALC: one iteration per cycle. At `cnt==XLEN-1`, go to DONE.
  - DONE: `out_valid=1`. On `out_ready`, leave DONE: go to IDLE, or straight to the next op if a new bundle is accepted the same cycle.
- `in_ready` = (state==IDLE) | (state==DONE & out_ready). This allows back-to-back base ops at one result per cycle.
- Operands and op are latched on accept. `out`, `zero` and `illegal` hold stable in DONE while `out_ready` is low.
- Multiply:
  - Form the magnitudes of the operands. MULHSU treats `in1` as signed and `in2` as unsigned; MULHU treats both as unsigned.
  - Compute an unsigned 2·XLEN product by XLEN shift-add steps.
  - Negate the product if the effective signs differ.
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- Divide:
  - Form the magnitudes and run an XLEN-step restoring divide.
  - Quotient sign = sign(in1) XOR sign(in2); remainder sign = sign(in1). Both apply only for the signed ops.
- Divide fast paths (no CALC, 1-cycle):
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return `in1`.
  - Signed overflow (`in1` = most-negative, `in2` = -1): DIV returns `in1`; REM returns 0.
- `kill` has priority over everything. Next cycle: state=IDLE, `out_valid=0`, and any bundle offered in the kill cycle is not accepted.
- Reset values: state IDLE, `out_valid=0`, `out=0`, `zero=0`, `illegal=0`, `cnt=0`. `in_ready=0` while `rst` is high and 1 on the first cycle after.

## Timing
- Accept at edge 0.
  - Base, illegal and fast-path ops: `out_valid` is high after edge 1.
  - Mul/div: `out_valid` is high after edge XLEN+1 (33 cycles for XLEN=32).
- Result is held indefinitely under backpressure; there is no timeout.
- `kill` in the same cycle as `out_ready` in DONE: the result is considered consumed, and state goes to IDLE.
- `rst` mid-CALC: state is IDLE next cycle and no partial result is emitted.
- `zero` and `illegal` update in the same register stage as `out`.

## Structure
- Package `alu_pkg` holds:
  - the `alu_op_e` enum (5-bit, codes above);
  - the `alu_state_e` enum;
  - helper functions `is_muldiv(op)`, `is_div(op)` and `is_signed_a/b(op)`.
- Sub-module `alu_md_iter` holds the iterative mul/div datapath: accumulator, shift registers and counter, with `start`/`done` handshake to the parent. The parent owns the FSM, base-op combinational logic, fast paths and output registers.

## Test plan
- ADD `in1=5`, `in2=7`, then SUB `5-5` back-to-back with `out_ready=1` -> `out=12`, `zero=0`, then `out=0`, `zero=1`, on consecutive cycles.
- MULH `0x80000000 × 0x80000000` -> `out=0x40000000`, with `out_valid` exactly 33 cycles after accept; MULHU `0xFFFFFFFF × 0xFFFFFFFF` -> `0xFFFFFFFE`.
- DIV -7/2 -> `0xFFFFFFFD`; REM -7/2 -> `0xFFFFFFFF`; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV `x/0` -> `0xFFFFFFFF` after 1 cycle; REM `0x1234/0` -> `0x1234`; DIV `0x80000000 / 0xFFFFFFFF` -> `0x80000000`; REM of the same -> 0.
- Hold `out_ready=0` for 10 cycles after a MUL `6×7` -> `out=42` stable, `in_ready=0`; illegal op 31 -> `out=0`, `illegal=1`.
- Assert `kill` at CALC cycle 10 of a DIV, then `rst` mid-MUL -> no `out_valid`; the next ADD `1+1` returns 2 at normal latency.
